// File: rtl/pipe_mem_pkg.sv
// Shared constants for the MEM stage: I/O register byte addresses and default data RAM size.
package pipe_mem_pkg;

  localparam int DMEM_AW_DEFAULT = 5;

  localparam logic [7:0] OUT0_ADDR = 8'h80;
  localparam logic [7:0] OUT1_ADDR = 8'h84;
  localparam logic [7:0] OUT2_ADDR = 8'h88;
  localparam logic [7:0] IN0_ADDR  = 8'hC0;
  localparam logic [7:0] IN1_ADDR  = 8'hC4;

endpackage

// File: rtl/pipe_dmem.sv
// Single-port data RAM with write enable and a read-first registered read port.
module pipe_dmem #(
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [2**AW];

  // The read samples the array before this edge's write lands, so a same-word
  // access returns the old contents.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/pipemwstage.sv
// MEM stage plus MEM/WB register: data RAM, board I/O port registers and WB outputs.
// Define PIPEMW_IN_SYNC_EN to pass in_port0/in_port1 through 2-flop synchronizers.
import pipe_mem_pkg::*;

module pipemwstage #(
  parameter int DMEM_AW = DMEM_AW_DEFAULT,
  parameter int IO_BIT  = 7
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);

  localparam int IOW = IO_BIT + 1;

  logic           is_io;
  logic [IO_BIT:0] io_word;
  logic           ram_we;
  logic [31:0]    ram_q;
  logic [31:0]    in0_v;
  logic [31:0]    in1_v;
  logic [31:0]    io_rdata;
  logic [31:0]    io_q;
  logic           ram_sel_q;

  assign is_io   = malu[IO_BIT];
  assign io_word = {malu[IO_BIT:2], 2'b00};
  assign ram_we  = resetn & mwmem & ~is_io;

  pipe_dmem #(
    .AW(DMEM_AW)
  ) u_dmem (
    .clock(clock),
    .we   (ram_we),
    .addr (malu[DMEM_AW+1:2]),
    .din  (mb),
    .dout (ram_q)
  );

`ifdef PIPEMW_IN_SYNC_EN
  logic [31:0] in0_s1;
  logic [31:0] in0_s2;
  logic [31:0] in1_s1;
  logic [31:0] in1_s2;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      in0_s1 <= '0;
      in0_s2 <= '0;
      in1_s1 <= '0;
      in1_s2 <= '0;
    end else begin
      in0_s1 <= in_port0;
      in0_s2 <= in0_s1;
      in1_s1 <= in_port1;
      in1_s2 <= in1_s1;
    end
  end

  assign in0_v = in0_s2;
  assign in1_v = in1_s2;
`else
  assign in0_v = in_port0;
  assign in1_v = in_port1;
`endif

  // RAM addresses have io_word[IO_BIT]=0 and so never match an I/O constant.
  always_comb begin
    io_rdata = '0;
    if (io_word == IOW'(OUT0_ADDR)) begin
      io_rdata = out_port0;
    end else if (io_word == IOW'(OUT1_ADDR)) begin
      io_rdata = out_port1;
    end else if (io_word == IOW'(OUT2_ADDR)) begin
      io_rdata = out_port2;
    end else if (io_word == IOW'(IN0_ADDR)) begin
      io_rdata = in0_v;
    end else if (io_word == IOW'(IN1_ADDR)) begin
      io_rdata = in1_v;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wwreg     <= 1'b0;
      wm2reg    <= 1'b0;
      walu      <= '0;
      wrn       <= '0;
      io_q      <= '0;
      ram_sel_q <= 1'b0;
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else begin
      wwreg     <= mwreg;
      wm2reg    <= mm2reg;
      walu      <= malu;
      wrn       <= mrn;
      io_q      <= io_rdata;
      ram_sel_q <= ~is_io;
      if (mwmem && io_word == IOW'(OUT0_ADDR)) begin
        out_port0 <= mb;
      end
      if (mwmem && io_word == IOW'(OUT1_ADDR)) begin
        out_port1 <= mb;
      end
      if (mwmem && io_word == IOW'(OUT2_ADDR)) begin
        out_port2 <= mb;
      end
    end
  end

  // The RAM word and the I/O word are both registered on the same edge; the
  // registered region select picks between them, and clears to the I/O side.
  assign wmo = ram_sel_q ? ram_q : io_q;

endmodule

// File: tb/tb_pipemwstage.sv
// Randomized self-checking bench for pipemwstage against a memory-map reference model.
// Honours PIPEMW_IN_SYNC_EN for the in_port latency.
module tb_pipemwstage;

  logic        clock;
  logic        resetn;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mrn;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic [31:0] ramModel [32];
  bit          ramKnown [32];
  logic [31:0] outModel [3];
  logic [31:0] hist0 [2];
  logic [31:0] hist1 [2];
  logic        eWwreg;
  logic        eWm2reg;
  logic [31:0] eWalu;
  logic [4:0]  eWrn;
  logic [31:0] eWmo;
  bit          eWmoKnown;

  pipemwstage dut (
    .clock    (clock),
    .resetn   (resetn),
    .mwreg    (mwreg),
    .mm2reg   (mm2reg),
    .mwmem    (mwmem),
    .malu     (malu),
    .mb       (mb),
    .mrn      (mrn),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wmo      (wmo),
    .walu     (walu),
    .wrn      (wrn),
    .out_port0(out_port0),
    .out_port1(out_port1),
    .out_port2(out_port2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one MEM-stage beat, advances one edge, then checks every output.
  task automatic applyStimulus(input logic rstn, input logic wr, input logic m2, input logic wm,
                               input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] rdata;
    logic [31:0] in0Seen;
    logic [31:0] in1Seen;
    bit          known;
    resetn = rstn;
    mwreg  = wr;
    mm2reg = m2;
    mwmem  = wm;
    malu   = alu;
    mb     = b;
    mrn    = rd;
`ifdef PIPEMW_IN_SYNC_EN
    in0Seen = hist0[1];
    in1Seen = hist1[1];
`else
    in0Seen = in_port0;
    in1Seen = in_port1;
`endif
    known = 1'b1;
    rdata = 32'h0;
    if (alu[7] == 1'b0) begin
      rdata = ramModel[alu[6:2]];
      known = ramKnown[alu[6:2]];
    end else begin
      case ({alu[7:2], 2'b00})
        8'h80:   rdata = outModel[0];
        8'h84:   rdata = outModel[1];
        8'h88:   rdata = outModel[2];
        8'hC0:   rdata = in0Seen;
        8'hC4:   rdata = in1Seen;
        default: rdata = 32'h0;
      endcase
    end
    @(posedge clock);
    if (!rstn) begin
      eWwreg = 0; eWm2reg = 0; eWalu = 0; eWrn = 0; eWmo = 0; eWmoKnown = 1;
      for (int i = 0; i < 3; i++) outModel[i] = 32'h0;
      hist0[0] = 0; hist0[1] = 0; hist1[0] = 0; hist1[1] = 0;
    end else begin
      eWwreg = wr; eWm2reg = m2; eWalu = alu; eWrn = rd; eWmo = rdata; eWmoKnown = known;
      if (wm) begin
        if (alu[7] == 1'b0) begin
          ramModel[alu[6:2]] = b;
          ramKnown[alu[6:2]] = 1'b1;
        end else begin
          case ({alu[7:2], 2'b00})
            8'h80:   outModel[0] = b;
            8'h84:   outModel[1] = b;
            8'h88:   outModel[2] = b;
            default: ;
          endcase
        end
      end
      hist0[1] = hist0[0]; hist0[0] = in_port0;
      hist1[1] = hist1[0]; hist1[0] = in_port1;
    end
    #1;
    checkOutput("wwreg", {31'b0, wwreg}, {31'b0, eWwreg});
    checkOutput("wm2reg", {31'b0, wm2reg}, {31'b0, eWm2reg});
    checkOutput("walu", walu, eWalu);
    checkOutput("wrn", {27'b0, wrn}, {27'b0, eWrn});
    if (eWmoKnown) checkOutput("wmo", wmo, eWmo);
    checkOutput("out_port0", out_port0, outModel[0]);
    checkOutput("out_port1", out_port1, outModel[1]);
    checkOutput("out_port2", out_port2, outModel[2]);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    logic [7:0]  pick [6];
    pick[0] = 8'h80; pick[1] = 8'h84; pick[2] = 8'h88;
    pick[3] = 8'hC0; pick[4] = 8'hC4; pick[5] = 8'h90;
    a = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      a[7] = 1'b0;
    end else begin
      a[7:2] = pick[$urandom_range(0, 5)][7:2];
    end
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      ramModel[i] = 32'h0;
      ramKnown[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) outModel[i] = 32'h0;
    hist0[0] = 0; hist0[1] = 0; hist1[0] = 0; hist1[1] = 0;
    in_port0 = 32'h0;
    in_port1 = 32'h0;
    resetn = 1'b0; mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mb = 0; mrn = 0;
    @(negedge clock);

    // Reset with a pending store to out_port0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'hFFFF_FFFF, 5'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'hFFFF_FFFF, 5'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd9);

    // Fill RAM so every later read has a known expectation
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, i * 4, $urandom, 5'd0);

    // RAM store then load
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 32'h1234_5678, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h04, 32'h0, 5'd3);
    checkOutput("load_ram", wmo, 32'h1234_5678);

    // Read-first collision
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 32'hAAAA_0000, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 32'h5555_FFFF, 5'd0);
    checkOutput("collision_old", wmo, 32'hAAAA_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h08, 32'h0, 5'd4);
    checkOutput("collision_new", wmo, 32'h5555_FFFF);

    // I/O ports
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0000_00F0, 5'd0);
    checkOutput("out0_store", out_port0, 32'hF0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd5);
    checkOutput("out0_load", wmo, 32'hF0);
    in_port1 = 32'h3;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hC4, 32'h0, 5'd6);
    checkOutput("in1_load", wmo, 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h90, 32'hCAFE_F00D, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0, 5'd6);
    checkOutput("unmapped_load", wmo, 32'h0);

    // Aliasing above the RAM index bits
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 32'hDEAD_BEEF, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0104, 32'h0, 5'd8);
    checkOutput("alias_load", wmo, 32'hDEAD_BEEF);

    // Pure ALU pass-through
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 5'($urandom));

    // Random mix including occasional reset and changing inputs
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) in_port0 = $urandom;
      if ($urandom_range(0, 7) == 0) in_port1 = $urandom;
      applyStimulus(($urandom_range(0, 29) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                    randAddr(), $urandom, 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
